// File: rtl/stopwatch_pkg.sv
// Shared encodings and helpers for the stopwatch controller.
// State codes, BCD types and button event indices.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_LAP     = 2'b10,
    ST_PAUSED  = 2'b11
  } sw_state_e;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd2_t;

  localparam int EV_CLEAR = 0;
  localparam int EV_STOP  = 1;
  localparam int EV_START = 2;
  localparam int EV_LAP   = 3;
  localparam int EV_NUM   = 4;

  // Two-digit BCD increment; tens wraps to 0 after max_tens.
  function automatic bcd2_t bcd2_inc(bcd2_t v, bcd_t max_tens);
    bcd2_t r;
    r = v;
    if (v.ones == bcd_t'(9)) begin
      r.ones = '0;
      if (v.tens == max_tens) r.tens = '0;
      else r.tens = v.tens + bcd_t'(1);
    end else begin
      r.ones = v.ones + bcd_t'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_controller_debounce.sv
// Pushbutton conditioner: 2-flop sync, debounce counter, press pulse.
// Emits a 1-cycle pulse on each accepted release-to-press transition.
module button_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = sync2_q;
      else cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign press = prev_q & ~level_q;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch sequencer: button FSM, seconds prescaler and 00-59 BCD count.
// Display registers show the frozen lap value while in LAP.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int MAX_TENS        = 5
) (
  input  logic             clk_50mhz,
  input  logic             reset,
  input  logic             start_n,
  input  logic             stop_n,
  input  logic             clear_n,
  input  logic             lap_n,
  output logic             tick,
  output logic [BCD_W-1:0] digit_ones,
  output logic [BCD_W-1:0] digit_tens,
  output logic             running,
  output logic             lap_hold,
  output logic             wrap
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [EV_NUM-1:0] btn_n;
  logic [EV_NUM-1:0] ev;

  assign btn_n[EV_CLEAR] = clear_n;
  assign btn_n[EV_STOP]  = stop_n;
  assign btn_n[EV_START] = start_n;
  assign btn_n[EV_LAP]   = lap_n;

  for (genvar i = 0; i < EV_NUM; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk  (clk_50mhz),
      .rst_n(reset),
      .btn_n(btn_n[i]),
      .press(ev[i])
    );
  end

  // Only the highest-priority event survives: clear > stop > start > lap.
  logic do_clear;
  logic do_stop;
  logic do_start;
  logic do_lap;

  assign do_clear = ev[EV_CLEAR];
  assign do_stop  = ev[EV_STOP] & ~ev[EV_CLEAR];
  assign do_start = ev[EV_START] & ~ev[EV_STOP] & ~ev[EV_CLEAR];
  assign do_lap   = ev[EV_LAP] & ~ev[EV_START]
                  & ~ev[EV_STOP] & ~ev[EV_CLEAR];

  sw_state_e       state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  bcd2_t           live_q, live_d;
  bcd2_t           lap_q, lap_d;
  bcd2_t           disp_q, disp_d;
  logic            running_q, running_d;
  logic            lap_hold_q, lap_hold_d;
  logic            run_act;

  assign run_act = (state_q == ST_RUNNING) || (state_q == ST_LAP);
  assign tick    = run_act && (presc_q == PW'(DIV - 1));
  assign wrap    = tick && (live_q.ones == bcd_t'(9))
                 && (live_q.tens == bcd_t'(MAX_TENS));

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    live_d  = live_q;
    lap_d   = lap_q;

    if (run_act) presc_d = tick ? '0 : presc_q + PW'(1);
    if (tick) live_d = bcd2_inc(live_q, bcd_t'(MAX_TENS));

    unique case (state_q)
      ST_IDLE: begin
        if (do_start) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        unique case (1'b1)
          do_clear: state_d = ST_IDLE;
          do_stop:  state_d = ST_PAUSED;
          do_lap: begin
            state_d = ST_LAP;
            lap_d   = live_q;
          end
          default: ;
        endcase
      end
      ST_LAP: begin
        unique case (1'b1)
          do_clear: state_d = ST_IDLE;
          do_stop:  state_d = ST_PAUSED;
          do_lap:   state_d = ST_RUNNING;
          default: ;
        endcase
      end
      ST_PAUSED: begin
        unique case (1'b1)
          do_clear: state_d = ST_IDLE;
          do_start: state_d = ST_RUNNING;
          default: ;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear beats a same-cycle tick: no increment survives into IDLE.
    if (state_d == ST_IDLE) begin
      presc_d = '0;
      live_d  = '0;
    end
  end

  always_comb begin
    running_d  = run_act;
    lap_hold_d = (state_q == ST_LAP);
    disp_d     = (state_q == ST_LAP) ? lap_q : live_q;
  end

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      live_q     <= '0;
      lap_q      <= '0;
      disp_q     <= '0;
      running_q  <= 1'b0;
      lap_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      live_q     <= live_d;
      lap_q      <= lap_d;
      disp_q     <= disp_d;
      running_q  <= running_d;
      lap_hold_q <= lap_hold_d;
    end
  end

  assign digit_ones = disp_q.ones;
  assign digit_tens = disp_q.tens;
  assign running    = running_q;
  assign lap_hold   = lap_hold_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller (DIV=10, debounce 4).
// Timeline table plus start/reset sequences.
module tb_stopwatch_controller;

  localparam logic [3:0] B_NONE  = 4'b1111;
  localparam logic [3:0] B_START = 4'b1110;
  localparam logic [3:0] B_STOP  = 4'b1101;
  localparam logic [3:0] B_CS    = 4'b1001;
  localparam logic [3:0] B_LAP   = 4'b0111;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_n = 1'b1;
  logic       stop_n = 1'b1;
  logic       clear_n = 1'b1;
  logic       lap_n = 1'b1;
  logic       tick;
  logic [3:0] digit_ones;
  logic [3:0] digit_tens;
  logic       running;
  logic       lap_hold;
  logic       wrap;

  stopwatch_controller #(
    .CLK_HZ(10),
    .TICK_HZ(1),
    .DEBOUNCE_CYCLES(4),
    .MAX_TENS(5)
  ) dut (
    .clk_50mhz (clk),
    .reset     (reset),
    .start_n   (start_n),
    .stop_n    (stop_n),
    .clear_n   (clear_n),
    .lap_n     (lap_n),
    .tick      (tick),
    .digit_ones(digit_ones),
    .digit_tens(digit_tens),
    .running   (running),
    .lap_hold  (lap_hold),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  int ec = 0;
  int org = 0;
  int pass_n = 0;
  int tot_n = 0;
  int tick_n = 0;
  int wrap_n = 0;
  int bad_wrap = 0;

  always @(posedge clk) ec <= ec + 1;

  always @(negedge clk) begin
    if (reset) begin
      if (tick) tick_n = tick_n + 1;
      if (wrap) wrap_n = wrap_n + 1;
      if (wrap && !tick) bad_wrap = bad_wrap + 1;
    end
  end

  typedef struct {
    int         k;
    logic [3:0] btn;
    logic       tk;
    logic       wr;
    logic       rn;
    logic       lh;
    logic [7:0] dg;
  } vec_t;

  vec_t v[$];

  task automatic add(int k, logic [3:0] b, logic tk, logic wr,
                     logic rn, logic lh, logic [7:0] dg);
    vec_t r;
    r.k = k; r.btn = b; r.tk = tk; r.wr = wr;
    r.rn = rn; r.lh = lh; r.dg = dg;
    v.push_back(r);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic set_btn(logic [3:0] b);
    {lap_n, clear_n, stop_n, start_n} = b;
  endtask

  // Advance to 2 ns after edge org+k.
  task automatic at(int k);
    while (ec < org + k) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic [7:0] dig();
    return {digit_tens, digit_ones};
  endfunction

  task automatic start_seq(string tag);
    org = ec;
    set_btn(B_START);
    at(7);  chk({tag, " run_before"}, running, 0);
    at(8);  chk({tag, " run_rise"}, running, 1);
    at(10); set_btn(B_NONE);
    at(15); chk({tag, " tick_early"}, tick, 0);
    at(16); chk({tag, " tick_first"}, tick, 1);
    at(17); chk({tag, " dig_00"}, dig(), 8'h00);
    at(18); chk({tag, " dig_01"}, dig(), 8'h01);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    add(0,   B_START, 0, 0, 0, 0, 8'h00);
    add(7,   B_START, 0, 0, 0, 0, 8'h00);
    add(8,   B_START, 0, 0, 1, 0, 8'h00);
    add(10,  B_NONE,  0, 0, 1, 0, 8'h00);
    add(16,  B_NONE,  1, 0, 1, 0, 8'h00);
    add(17,  B_NONE,  0, 0, 1, 0, 8'h00);
    add(18,  B_STOP,  0, 0, 1, 0, 8'h01);
    add(20,  B_NONE,  0, 0, 1, 0, 8'h01);
    add(22,  B_STOP,  0, 0, 1, 0, 8'h01);
    add(24,  B_NONE,  0, 0, 1, 0, 8'h01);
    add(26,  B_STOP,  1, 0, 1, 0, 8'h01);
    add(28,  B_NONE,  0, 0, 1, 0, 8'h02);
    add(30,  B_STOP,  0, 0, 1, 0, 8'h02);
    add(32,  B_NONE,  0, 0, 1, 0, 8'h02);
    add(34,  B_STOP,  0, 0, 1, 0, 8'h02);
    add(36,  B_NONE,  1, 0, 1, 0, 8'h02);
    add(38,  B_NONE,  0, 0, 1, 0, 8'h03);
    add(42,  B_STOP,  0, 0, 1, 0, 8'h03);
    add(48,  B_NONE,  0, 0, 1, 0, 8'h04);
    add(49,  B_NONE,  0, 0, 1, 0, 8'h04);
    add(50,  B_NONE,  0, 0, 0, 0, 8'h04);
    add(57,  B_START, 0, 0, 0, 0, 8'h04);
    add(63,  B_NONE,  0, 0, 0, 0, 8'h04);
    add(64,  B_NONE,  0, 0, 0, 0, 8'h04);
    add(65,  B_NONE,  0, 0, 1, 0, 8'h04);
    add(70,  B_NONE,  0, 0, 1, 0, 8'h04);
    add(71,  B_NONE,  1, 0, 1, 0, 8'h04);
    add(73,  B_NONE,  0, 0, 1, 0, 8'h05);
    add(613, B_NONE,  0, 0, 1, 0, 8'h59);
    add(621, B_NONE,  1, 1, 1, 0, 8'h59);
    add(622, B_NONE,  0, 0, 1, 0, 8'h59);
    add(623, B_NONE,  0, 0, 1, 0, 8'h00);
    add(743, B_LAP,   0, 0, 1, 0, 8'h12);
    add(749, B_NONE,  0, 0, 1, 0, 8'h12);
    add(750, B_NONE,  0, 0, 1, 0, 8'h12);
    add(751, B_NONE,  1, 0, 1, 1, 8'h12);
    add(780, B_NONE,  0, 0, 1, 1, 8'h12);
    add(793, B_LAP,   0, 0, 1, 1, 8'h12);
    add(799, B_NONE,  0, 0, 1, 1, 8'h12);
    add(800, B_NONE,  0, 0, 1, 1, 8'h12);
    add(801, B_NONE,  1, 0, 1, 0, 8'h17);
    add(802, B_NONE,  0, 0, 1, 0, 8'h17);
    add(965, B_CS,    0, 0, 1, 0, 8'h34);
    add(971, B_NONE,  1, 0, 1, 0, 8'h34);
    add(972, B_NONE,  0, 0, 1, 0, 8'h34);
    add(973, B_NONE,  0, 0, 0, 0, 8'h00);
    add(990, B_NONE,  0, 0, 0, 0, 8'h00);

    set_btn(B_NONE);
    repeat (3) @(posedge clk);
    #2;
    chk("rst tick", tick, 0);
    chk("rst wrap", wrap, 0);
    chk("rst running", running, 0);
    chk("rst lap_hold", lap_hold, 0);
    chk("rst digits", dig(), 8'h00);
    reset = 1'b1;
    @(posedge clk);
    #2;

    org = ec;
    for (int i = 0; i < v.size(); i++) begin
      at(v[i].k);
      chk($sformatf("v%0d k%0d tick", i, v[i].k), tick, v[i].tk);
      chk($sformatf("v%0d k%0d wrap", i, v[i].k), wrap, v[i].wr);
      chk($sformatf("v%0d k%0d running", i, v[i].k), running, v[i].rn);
      chk($sformatf("v%0d k%0d lap_hold", i, v[i].k), lap_hold, v[i].lh);
      chk($sformatf("v%0d k%0d digits", i, v[i].k), dig(), v[i].dg);
      set_btn(v[i].btn);
    end

    chk("tick count", tick_n, 95);
    chk("wrap count", wrap_n, 1);
    chk("wrap without tick", bad_wrap, 0);

    start_seq("restart");
    at(420);
    chk("pre-reset digits", dig(), 8'h41);
    chk("pre-reset running", running, 1);
    #3;
    reset = 1'b0;
    #1;
    chk("async tick", tick, 0);
    chk("async wrap", wrap, 0);
    chk("async running", running, 0);
    chk("async lap_hold", lap_hold, 0);
    chk("async digits", dig(), 8'h00);
    repeat (2) @(posedge clk);
    #2;
    chk("in-reset digits", dig(), 8'h00);
    reset = 1'b1;
    @(posedge clk);
    #2;
    chk("post-reset running", running, 0);
    chk("post-reset digits", dig(), 8'h00);
    chk("post-reset tick", tick, 0);
    start_seq("after_reset");

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule

// File: doc/stopwatch_controller.md
Name: stopwatch_controller

Overview:
- Sequencing controller for the board stopwatch datapath.
- Debounces four active-low pushbuttons and runs an IDLE/RUNNING/LAP/PAUSED state machine.
- Generates the 1-cycle seconds tick from the 50 MHz clock and owns the 00–59 BCD seconds count (ones and tens).
- Drives two BCD digits to downstream seven-segment decoders, with lap-freeze support.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 1, count rate. DIV = CLK_HZ/TICK_HZ. DIV must be at least 2.
- DEBOUNCE_CYCLES, 500_000, consecutive stable cycles required before a button level is accepted (10 ms).
- MAX_TENS, 5, tens digit at which 9 rolls over to 00 (5 gives a 59 wrap).

Ports:
- clk_50mhz  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_n  in  1  start button, active-low, asynchronous to the clock.
- stop_n  in  1  stop button, active-low.
- clear_n  in  1  clear button, active-low.
- lap_n  in  1  lap toggle button, active-low.
- tick  out  1  1-cycle pulse when the seconds count advances.
- digit_ones  out  4  displayed BCD ones digit.
- digit_tens  out  4  displayed BCD tens digit.
- running  out  1  high in RUNNING or LAP.
- lap_hold  out  1  high in LAP (display frozen).
- wrap  out  1  1-cycle pulse on the 59->00 rollover, coincident with tick.

Behaviour:
- Reset (reset low, asynchronous):
  - State = IDLE; prescaler = 0; live count = 00; lap register = 00.
  - All outputs 0.
  - Debounced button levels = 1 (released); synchronizer flops = 1.
- Button path, per input:
  - 2-flop synchronizer, then debounce counter.
  - The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - Press event = debounced 1->0 transition; it is a 1-cycle internal pulse.
  - Release generates no event.
- Event priority within one cycle: clear > stop > start > lap. Only the highest-priority event is acted on; the rest are dropped.
- State transitions (take effect on the edge where the event pulse is high):
  - IDLE: start -> RUNNING. All other events are ignored.
  - RUNNING: stop -> PAUSED; lap -> LAP, capturing the live count into the lap register on the same edge; clear -> IDLE.
  - LAP: lap -> RUNNING; stop -> PAUSED, after which the display shows the live value; clear -> IDLE. start is ignored.
  - PAUSED: start -> RUNNING; clear -> IDLE. stop and lap are ignored.
  - Entering IDLE: prescaler and live count are zeroed on the same edge.
- Prescaler:
  - Counts 0..DIV-1 only in RUNNING or LAP.
  - Holds its value in PAUSED, so resume keeps the fractional second.
  - tick is asserted combinationally while prescaler == DIV-1 and the state is RUNNING or LAP. The prescaler returns to 0 on that edge.
- Count:
  - On a tick edge, ones increments. If ones == 9, ones becomes 0 and tens increments.
  - If tens == MAX_TENS and ones == 9, the count becomes 00 and wrap pulses with tick.
  - Counting continues during LAP.
  - A clear on a tick cycle wins: the count becomes 00 and no increment occurs.
- Display outputs:
  - digit_ones and digit_tens are registered.
  - They show the lap register in LAP and the live count otherwise.
  - They update one cycle after the edge that changes the live count or the state.
- Latency: from a clean button press to its state change is 2 + DEBOUNCE_CYCLES + 1 cycles, plus 1 cycle for running/lap_hold to reflect it.
- A press held indefinitely produces exactly one event.

Decomposition:
- Shared package stopwatch_pkg contains:
  - State encoding: IDLE=2'b00, RUNNING=2'b01, LAP=2'b10, PAUSED=2'b11.
  - BCD width constant (4).
  - Event-index constants for clear, stop, start and lap.
- One natural sub-module: button_debounce (synchronizer, debounce counter, falling-edge pulse), parameterized by DEBOUNCE_CYCLES and instantiated four times.
- The FSM, prescaler and BCD count stay in stopwatch_controller.

Test Plan (bench parameters CLK_HZ=10, TICK_HZ=1, DEBOUNCE_CYCLES=4, so DIV=10):
- Reset and start:
  - Stimulus: hold reset low, release, then press start_n for 10 cycles.
  - Required: running rises 7 cycles after start_n falls; the first tick follows 10 cycles after entering RUNNING; digits read 01 one cycle after that tick.
- Bounce rejection:
  - Stimulus: toggle stop_n low/high every 2 cycles for 20 cycles while RUNNING.
  - Required: no state change. A subsequent clean 6-cycle low gives PAUSED; the prescaler holds its value and the next tick after start arrives after the remaining cycles only.
- Rollover:
  - Stimulus: run 59 ticks, then 1 more tick.
  - Required: digits 59, then 00, with wrap and tick high on the same cycle exactly once.
- Lap freeze:
  - Stimulus: at count 12, press lap; run 5 ticks; press lap again.
  - Required: lap_hold=1 and digits stay 12 throughout; after the second press the digits show 17 and lap_hold=0.
- Simultaneous events:
  - Stimulus: press clear_n and stop_n on the same cycle while RUNNING at 34, aligned to a tick cycle.
  - Required: state IDLE, digits 00, running=0, no increment.
- Asynchronous reset mid-run:
  - Stimulus: pull reset low at count 41 between clock edges.
  - Required: all outputs 0 immediately, before the next edge; after release, state is IDLE and start behaves as in the first scenario.
